// File: rtl/chesssoc_pio_pkg.sv
// Shared definitions for the chess SoC PIO slaves: register addresses and STATUS layout.
package chesssoc_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    // STATUS word: phase in bit 0, blink counter from bit 1 upwards
    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_CNT_LSB   = 1;

endpackage

// File: rtl/chesssoc_blink_timer.sv
// Blink period down-counter: reloads from period at terminal count and toggles phase.
module chesssoc_blink_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] period,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             phase,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            phase <= 1'b0;
        end else if (load) begin
            // a PERIOD write restarts the blink cycle, even on an expiry edge
            count <= load_value;
            phase <= 1'b0;
        end else if (period == '0) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == '0) begin
            count <= period;
            phase <= ~phase;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/chesssoc_led_pio.sv
// Avalon-MM output PIO with set/clear aliases and a hardware blink engine.
module chesssoc_led_pio
    import chesssoc_pio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] period_q;
    logic             phase;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             period_load;
    logic [31:0]      rd_mux;
    logic [WIDTH-1:0] wr_bits;
    logic [CNT_W-1:0] wr_period;
    logic             unused_wd;

    assign wr_en       = chipselect && !write_n;
    assign period_load = wr_en && (address == ADDR_PERIOD);
    assign wr_bits     = writedata[WIDTH-1:0];
    assign wr_period   = writedata[CNT_W-1:0];
    assign unused_wd   = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            mask_q   <= '0;
            period_q <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_q   <= wr_bits;
                ADDR_MASK:   mask_q   <= wr_bits;
                ADDR_PERIOD: period_q <= wr_period;
                ADDR_OUTSET: data_q   <= data_q | wr_bits;
                ADDR_OUTCLR: data_q   <= data_q & ~wr_bits;
                default:     ;
            endcase
        end
    end

    chesssoc_blink_timer #(.CNT_W(CNT_W)) u_blink_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .period     (period_q),
        .load       (period_load),
        .load_value (wr_period),
        .phase      (phase),
        .count      (count)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux = 32'(data_q);
            ADDR_MASK:   rd_mux = 32'(mask_q);
            ADDR_PERIOD: rd_mux = 32'(period_q);
            ADDR_STATUS: begin
                rd_mux = 32'(count) << STATUS_CNT_LSB;
                rd_mux[STATUS_PHASE_BIT] = phase;
            end
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            out_port <= '0;
        end else begin
            readdata <= rd_mux;
            out_port <= data_q ^ (mask_q & {WIDTH{phase}});
        end
    end

endmodule
